// File: rtl/score_accumulator.sv
// 4-digit BCD score register: adds or subtracts a single BCD digit one
// digit per clock, saturating at 9999 / clamping at 0000, committed atomically.
module score_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        req,
    input  logic        op,
    input  logic [3:0]  delta,
    output logic        busy,
    output logic        done,
    output logic        sat,
    output logic [15:0] score
);

    typedef enum logic [1:0] {
        IDLE,
        DIG,
        COMMIT
    } state_t;

    state_t          state;
    logic [1:0]      idx;
    logic            op_r;
    logic [3:0]      delta_r;
    logic [3:0][3:0] work;
    logic            c;

    logic [3:0] operand;
    logic [3:0] dig_cur;
    logic [3:0] dig_next;
    logic       c_next;
    logic [4:0] t;

    // One BCD digit step; t[4] flags a negative difference on subtract.
    always_comb begin
        operand  = (idx == 2'd0) ? delta_r : 4'd0;
        dig_cur  = work[idx];
        t        = '0;
        dig_next = '0;
        c_next   = 1'b0;
        if (!op_r) begin
            t = {1'b0, dig_cur} + {1'b0, operand} + {4'd0, c};
            if (t > 5'd9) begin
                dig_next = 4'(t - 5'd10);
                c_next   = 1'b1;
            end else begin
                dig_next = t[3:0];
            end
        end else begin
            t = {1'b0, dig_cur} - {1'b0, operand} - {4'd0, c};
            if (t[4]) begin
                dig_next = 4'(t + 5'd10);
                c_next   = 1'b1;
            end else begin
                dig_next = t[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            op_r    <= 1'b0;
            delta_r <= '0;
            work    <= '0;
            c       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            score   <= '0;
        end else begin
            done <= 1'b0;
            sat  <= 1'b0;
            if (clr) begin
                // Clear wins in every state; an in-flight event is dropped silently.
                score <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            op_r    <= op;
                            delta_r <= (delta > 4'd9) ? 4'd9 : delta;
                            work    <= score;
                            c       <= 1'b0;
                            idx     <= '0;
                            busy    <= 1'b1;
                            state   <= DIG;
                        end
                    end
                    DIG: begin
                        work[idx] <= dig_next;
                        c         <= c_next;
                        if (idx == 2'd3) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    COMMIT: begin
                        if (c) begin
                            score <= op_r ? 16'h0000 : 16'h9999;
                            sat   <= 1'b1;
                        end else begin
                            score <= work;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Sequential BCD score register that sits directly downstream of the 4-bit add/subtract datapath in the scoring path. It accepts one hit/miss event per handshake and adds or subtracts a single-digit point value to a 4-digit BCD score, one digit per clock, with decimal carry/borrow rippled between cycles. It saturates at 9999 and clamps at 0000, and it publishes the new score atomically to the display logic.

## Interface
Parameters: none; width and digit count are fixed.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous score clear; takes priority over req
- req  in  1  event request; sampled only while busy=0
- op  in  1  0 = add delta, 1 = subtract delta
- delta  in  4  points, BCD 0–9; values 10–15 are treated as 9
- busy  out  1  high while an event is in progress (DIG or COMMIT)
- done  out  1  one-cycle pulse when the new score is committed
- sat  out  1  one-cycle pulse coincident with done if the result was clamped
- score  out  16  committed score, 4 BCD digits, [15:12] = thousands

## Operation
- Reset (rst=1 at an edge): score=16'h0000, busy=0, done=0, sat=0, FSM=IDLE, working registers cleared.
- FSM states are IDLE, DIG, COMMIT. A 2-bit digit index idx runs 0..3.
- IDLE: if clr=1, score<=0 and req is ignored. Otherwise, if req=1, latch op and clamped delta, copy score to the working register, set carry/borrow to 0, set idx=0, and go to DIG.
- DIG, one digit per cycle, idx=0..3. The operand is delta for idx=0 and 0 for idx>0.
  - Add: t = digit + operand + c. If t > 9, the digit becomes t−10 and c=1; otherwise the digit becomes t and c=0.
  - Subtract: t = digit − operand − c, computed on 5 bits. If t < 0, the digit becomes t+10 and c=1; otherwise the digit becomes t and c=0.
  - At idx=3 go to COMMIT; otherwise increment idx.
- COMMIT:
  - c=1 on add: score<=16'h9999, sat<=1.
  - c=1 on subtract: score<=16'h0000, sat<=1.
  - Otherwise score<=working register, sat<=0.
  - In all cases done<=1 and the FSM returns to IDLE.
- score changes only in COMMIT, on clr in IDLE, or on reset. Partial results are never visible.
- req while busy=1 is ignored. There is no queueing, and the requester must wait for busy=0.
- clr while busy=1 aborts the event: score<=0, FSM<=IDLE, no done, no sat.
- rst has priority over everything.

## Timing
- req sampled high at edge k in IDLE: busy=1 from after edge k.
- Digits 0..3 are computed at edges k+1..k+4, and the FSM is in COMMIT after edge k+4.
- Edge k+5: score updated, done=1 and sat valid for exactly the cycle after edge k+5, busy=0.
- Latency is 5 cycles from request to visible score. Throughput is one event per 6 cycles, since a new req can be sampled at edge k+6 at the earliest.
- done and sat are registered and are 0 in every cycle except the one following a COMMIT edge.
- clr in IDLE takes effect at the sampling edge. score reads 0 in the following cycle, and done is not asserted.

## Test plan
- Reset: drive rst for 2 cycles with req=1 → score=0000, busy=0, done=0, sat=0, and no event starts.
- Basic add: from 0000, add 7 → score 0007 exactly 5 edges after req, with done pulse width 1. Then add 5 → 0012, sat=0.
- Ripple: from 0999, add 1 → 1000. From 1000, subtract 1 → 0999. From 0300, subtract 9 → 0291.
- Saturation: from 9995, add 9 → 9999 with sat=1. From 0002, subtract 3 → 0000 with sat=1. delta=4'hF on add from 0000 → 0009.
- Protocol: a second req pulse held during busy is ignored (only one done occurs, and the score reflects one event). A back-to-back req at the first legal edge is accepted.
- Abort:
  - clr asserted in the DIG cycle at idx=2 → score=0000 next cycle, no done, busy=0.
  - rst mid-event → all outputs at reset values.
  - clr and req together in IDLE → score=0000, no event.
